pipeline_control_ldst_responder: RTL and testbench
==================================================

Name: pipeline_control_ldst_responder

Overview:
- Target end of the pipeline-control load/store interface used by the IRQ-call and handler-read sequencers.
- Accepts one request at a time and converts it to a word-aligned data-memory bus access with a byte mask.
- Returns a single-cycle response carrying read data, zero-extended and right-justified.
- Sits between the pipeline-control sequencers and the L1 data-memory port.

Parameters:
- ADDR_W, 32, byte-address width (fixed 32 in this core).
- DATA_W, 32, data width (fixed 32).

Ports:
- iCLOCK  in  1  core clock.
- inRESET  in  1  reset, synchronous, active-low.
- iRESET_SYNC  in  1  synchronous soft reset, active-high.
- iLDST_USE  in  1  requester owns the port.
- iLDST_REQ  in  1  request strobe.
- oLDST_BUSY  out  1  responder cannot accept a request.
- iLDST_ORDER  in  2  access size: 00 byte, 01 halfword, 10 word, 11 none.
- iLDST_RW  in  1  0 = read, 1 = write.
- iLDST_ADDR  in  32  byte address.
- iLDST_DATA  in  32  write data, right-justified.
- oLDST_VALID  out  1  response pulse.
- oLDST_DATA  out  32  read data, right-justified and zero-extended; 0 for writes.
- oLDST_FAULT  out  1  misalignment fault; present only with the optional feature, otherwise tied 0.
- oMEM_REQ  out  1  memory request.
- iMEM_LOCK  in  1  memory busy; the request is held while this is high.
- oMEM_MASK  out  4  byte enables; bit3 = bits 31:24.
- oMEM_RW  out  1  memory read/write.
- oMEM_ADDR  out  32  word address, {addr[31:2], 2'b00}.
- oMEM_DATA  out  32  lane-positioned write data.
- iMEM_VALID  in  1  read data valid, or write acknowledge.
- iMEM_DATA  in  32  memory read word.

Behaviour:
- Reset
  - inRESET low, or iRESET_SYNC high, at a clock edge: state goes to IDLE.
  - All outputs go to 0, including oLDST_BUSY and every latched field.
  - Reset mid-access abandons the access; a late iMEM_VALID arriving in IDLE is ignored.
- Byte lanes (big-endian)
  - Byte: addr[1:0]=0..3 selects mask 1000/0100/0010/0001.
  - Halfword: addr[1]=0 gives 1100; addr[1]=1 gives 0011.
  - Word: mask 1111.
  - ORDER=11: mask 0000. The access still completes as a normal handshake.
  - Writes: data is replicated into the selected lane (byte into all 4 lanes, halfword into both halves).
  - Reads: the selected lane is shifted down and zero-extended.
- State machine, 2-bit
  - IDLE:
    - Accept when iLDST_USE and iLDST_REQ are both high.
    - Latch ORDER, RW, ADDR and DATA, then go to MEM_REQ.
  - MEM_REQ:
    - oMEM_REQ = 1, driven combinationally from state with latched fields.
    - If iMEM_LOCK is low this cycle, go to MEM_WAIT; otherwise hold.
  - MEM_WAIT:
    - oMEM_REQ = 0.
    - On iMEM_VALID, capture the extracted data (0 if write) and go to DONE.
  - DONE:
    - oLDST_VALID = 1 for exactly one cycle, with oLDST_DATA valid.
    - Next state is IDLE.
- Busy and request timing
  - oLDST_BUSY = (state != IDLE), registered with state.
  - A request arriving while busy is ignored; the requester must hold it.
  - A request in the same cycle as DONE is ignored. The earliest next acceptance is the cycle after DONE.
- Latency
  - Best case (lock low, memory valid 1 cycle after request): accept at edge 0, MEM_REQ in cycle 1, MEM_WAIT in cycle 2, oLDST_VALID in cycle 3.
- Simultaneous events
  - iMEM_VALID in MEM_REQ is ignored.
  - oLDST_DATA holds its value until the next DONE.

Optional Feature:
- Macro: PIPELINE_CONTROL_LDST_ALIGN_CHECK_EN.
- Enabled, a request is misaligned if:
  - halfword with addr[0]=1, or
  - word with addr[1:0]!=0.
- Enabled, a misaligned request:
  - is accepted and goes IDLE to DONE directly, with no memory request;
  - in DONE, oLDST_VALID = 1, oLDST_FAULT = 1 and oLDST_DATA = 0.
- Disabled:
  - no check; the low address bits beyond the access size are ignored for masking;
  - oLDST_FAULT is constant 0.

Decomposition:
- Shared package core_ldst_pkg holds:
  - order encodings (ORDER_BYTE, ORDER_HALF, ORDER_WORD, ORDER_NONE);
  - state encodings (ST_IDLE, ST_MEM_REQ, ST_MEM_WAIT, ST_DONE).
- One natural sub-module, pipeline_control_ldst_lane, which is purely combinational. It provides:
  - mask and write-data placement from order/addr;
  - read-data extraction.

Test Plan:
- Word read: addr 0x0000_0104, ORDER=10; memory returns 0xDEAD_BEEF one cycle later.
  -> oMEM_ADDR=0x104, mask 1111, oLDST_VALID in cycle 3, data 0xDEAD_BEEF.
- Byte read: addr 0x0000_0106, memory word 0x1122_3344.
  -> mask 0010, oLDST_DATA=0x0000_0033.
- Halfword write: addr 0x0000_0002, data 0x0000_ABCD.
  -> mask 0011, oMEM_DATA=0xABCD_ABCD, RW=1; response data 0 on ack.
- iMEM_LOCK high for 3 cycles in MEM_REQ.
  -> oMEM_REQ held with stable fields; oLDST_BUSY stays 1; a second iLDST_REQ is ignored.
- iRESET_SYNC pulsed in MEM_WAIT, then iMEM_VALID arrives.
  -> state IDLE, BUSY 0, no oLDST_VALID.
- With the macro defined: word read at 0x0000_0102.
  -> no oMEM_REQ; one-cycle VALID+FAULT; data 0.
- Without the macro: the same request.
  -> normal access with mask 1111.

Source files
------------

// File: rtl/core_ldst_pkg.sv
// Shared encodings for the pipeline-control load/store port: access orders and responder states.
// The alignment helper is used only when PIPELINE_CONTROL_LDST_ALIGN_CHECK_EN is defined.
package core_ldst_pkg;

  localparam logic [1:0] ORDER_BYTE = 2'b00;
  localparam logic [1:0] ORDER_HALF = 2'b01;
  localparam logic [1:0] ORDER_WORD = 2'b10;
  localparam logic [1:0] ORDER_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MEM_REQ  = 2'b01,
    ST_MEM_WAIT = 2'b10,
    ST_DONE     = 2'b11
  } state_t;

  // A halfword must sit on an even byte and a word on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] order, input logic [1:0] addr_lo);
    return ((order == ORDER_HALF) && addr_lo[0]) ||
           ((order == ORDER_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/pipeline_control_ldst_lane.sv
// Big-endian byte-lane logic: byte mask and write-data replication from order/address,
// and right-justified, zero-extended extraction of read data.
module pipeline_control_ldst_lane
  import core_ldst_pkg::*;
(
  input  logic [1:0]  order,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  mask,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);

  // Lane 0 is the most significant byte of the memory word.
  logic [7:0] byte_lane [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_lane[gi] = rword[31 - 8*gi -: 8];
  end

  always_comb begin
    mask  = 4'b0000;
    wlane = '0;
    rdata = '0;
    case (order)
      ORDER_BYTE: begin
        mask  = 4'b1000 >> addr_lo;
        wlane = {4{wdata[7:0]}};
        rdata = {24'b0, byte_lane[addr_lo]};
      end
      ORDER_HALF: begin
        mask  = addr_lo[1] ? 4'b0011 : 4'b1100;
        wlane = {2{wdata[15:0]}};
        rdata = addr_lo[1] ? {16'b0, rword[15:0]} : {16'b0, rword[31:16]};
      end
      ORDER_WORD: begin
        mask  = 4'b1111;
        wlane = wdata;
        rdata = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_control_ldst_responder.sv
// Single-outstanding load/store responder: one request becomes one word-aligned, byte-masked
// memory access. Optional alignment fault via PIPELINE_CONTROL_LDST_ALIGN_CHECK_EN.
module pipeline_control_ldst_responder
  import core_ldst_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              iCLOCK,
  input  logic              inRESET,
  input  logic              iRESET_SYNC,
  input  logic              iLDST_USE,
  input  logic              iLDST_REQ,
  output logic              oLDST_BUSY,
  input  logic [1:0]        iLDST_ORDER,
  input  logic              iLDST_RW,
  input  logic [ADDR_W-1:0] iLDST_ADDR,
  input  logic [DATA_W-1:0] iLDST_DATA,
  output logic              oLDST_VALID,
  output logic [DATA_W-1:0] oLDST_DATA,
  output logic              oLDST_FAULT,
  output logic              oMEM_REQ,
  input  logic              iMEM_LOCK,
  output logic [3:0]        oMEM_MASK,
  output logic              oMEM_RW,
  output logic [ADDR_W-1:0] oMEM_ADDR,
  output logic [DATA_W-1:0] oMEM_DATA,
  input  logic              iMEM_VALID,
  input  logic [DATA_W-1:0] iMEM_DATA
);

  state_t            state_reg, state_next;
  logic [1:0]        order_reg;
  logic              rw_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic              accept;
  logic              misaligned_req;
  logic              mem_active;
  logic [3:0]        lane_mask;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_rdata;

  assign accept = (state_reg == ST_IDLE) && iLDST_USE && iLDST_REQ;

`ifdef PIPELINE_CONTROL_LDST_ALIGN_CHECK_EN
  logic fault_reg;

  assign misaligned_req = is_misaligned(iLDST_ORDER, iLDST_ADDR[1:0]);

  always_ff @(posedge iCLOCK) begin
    if (!inRESET || iRESET_SYNC) begin
      fault_reg <= 1'b0;
    end else if (accept) begin
      fault_reg <= misaligned_req;
    end
  end

  assign oLDST_FAULT = fault_reg && (state_reg == ST_DONE);
`else
  assign misaligned_req = 1'b0;
  assign oLDST_FAULT    = 1'b0;
`endif

  pipeline_control_ldst_lane u_lane (
    .order   (order_reg),
    .addr_lo (addr_reg[1:0]),
    .wdata   (wdata_reg),
    .rword   (iMEM_DATA),
    .mask    (lane_mask),
    .wlane   (lane_wdata),
    .rdata   (lane_rdata)
  );

  always_ff @(posedge iCLOCK) begin
    if (!inRESET || iRESET_SYNC) begin
      state_reg <= ST_IDLE;
      order_reg <= ORDER_BYTE;
      rw_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        order_reg <= iLDST_ORDER;
        rw_reg    <= iLDST_RW;
        addr_reg  <= iLDST_ADDR;
        wdata_reg <= iLDST_DATA;
        // A faulting access skips memory, so its response data is cleared here.
        if (misaligned_req) begin
          rdata_reg <= '0;
        end
      end
      if ((state_reg == ST_MEM_WAIT) && iMEM_VALID) begin
        rdata_reg <= rw_reg ? '0 : lane_rdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (accept) state_next = misaligned_req ? ST_DONE : ST_MEM_REQ;
      ST_MEM_REQ:  if (!iMEM_LOCK) state_next = ST_MEM_WAIT;
      ST_MEM_WAIT: if (iMEM_VALID) state_next = ST_DONE;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Memory-side fields are only presented while the request is asserted.
  assign mem_active  = (state_reg == ST_MEM_REQ);
  assign oMEM_REQ    = mem_active;
  assign oMEM_RW     = mem_active && rw_reg;
  assign oMEM_MASK   = mem_active ? lane_mask : 4'b0000;
  assign oMEM_ADDR   = mem_active ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
  assign oMEM_DATA   = mem_active ? lane_wdata : '0;
  assign oLDST_BUSY  = (state_reg != ST_IDLE);
  assign oLDST_VALID = (state_reg == ST_DONE);
  assign oLDST_DATA  = rdata_reg;

endmodule

// File: tb/tb_pipeline_control_ldst_responder.sv
// Randomized transaction-level bench for pipeline_control_ldst_responder; per-cycle comparison
// against expectations derived from the access rules, plus literal checks of directed cases.
module tb_pipeline_control_ldst_responder;

  logic        iCLOCK = 1'b0;
  logic        inRESET, iRESET_SYNC, iLDST_USE, iLDST_REQ, iLDST_RW;
  logic [1:0]  iLDST_ORDER;
  logic [31:0] iLDST_ADDR, iLDST_DATA, iMEM_DATA;
  logic        iMEM_LOCK, iMEM_VALID;
  logic        oLDST_BUSY, oLDST_VALID, oLDST_FAULT, oMEM_REQ, oMEM_RW;
  logic [31:0] oLDST_DATA, oMEM_ADDR, oMEM_DATA;
  logic [3:0]  oMEM_MASK;

  always #5 iCLOCK = ~iCLOCK;

  pipeline_control_ldst_responder dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iLDST_USE(iLDST_USE), .iLDST_REQ(iLDST_REQ), .oLDST_BUSY(oLDST_BUSY),
    .iLDST_ORDER(iLDST_ORDER), .iLDST_RW(iLDST_RW), .iLDST_ADDR(iLDST_ADDR),
    .iLDST_DATA(iLDST_DATA), .oLDST_VALID(oLDST_VALID), .oLDST_DATA(oLDST_DATA),
    .oLDST_FAULT(oLDST_FAULT), .oMEM_REQ(oMEM_REQ), .iMEM_LOCK(iMEM_LOCK),
    .oMEM_MASK(oMEM_MASK), .oMEM_RW(oMEM_RW), .oMEM_ADDR(oMEM_ADDR),
    .oMEM_DATA(oMEM_DATA), .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle, set by the driver from the transaction it is running.
  logic        exp_busy, exp_req, exp_valid, exp_fault, exp_rw;
  logic [3:0]  exp_mask;
  logic [31:0] exp_addr, exp_mdata, exp_ldata;
  logic [31:0] last_resp;

  logic [3:0]  seen_mask;
  logic [31:0] seen_maddr, seen_mdata, seen_resp;
  logic        seen_fault;
  int          req_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_mask(input logic [1:0] o, input logic [1:0] a);
    logic [3:0] one_hot;
    one_hot = 4'b1000;
    case (o)
      2'b00:   return one_hot >> a;
      2'b01:   return a[1] ? 4'b0011 : 4'b1100;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] o, input logic [31:0] d);
    case (o)
      2'b00:   return {24'b0, d[7:0]} * 32'h0101_0101;
      2'b01:   return {16'b0, d[15:0]} * 32'h0001_0001;
      2'b10:   return d;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] o, input logic [1:0] a, input logic [31:0] w);
    case (o)
      2'b00:   return (w >> (8 * (3 - int'(a)))) & 32'h0000_00FF;
      2'b01:   return a[1] ? (w & 32'h0000_FFFF) : (w >> 16);
      2'b10:   return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_misaligned(input logic [1:0] o, input logic [1:0] a);
`ifdef PIPELINE_CONTROL_LDST_ALIGN_CHECK_EN
    return (o == 2'b01 && a[0]) || (o == 2'b10 && a != 2'b00);
`else
    return (o == 2'b11) && (a == 2'b11) && 1'b0;
`endif
  endfunction

  always @(negedge iCLOCK) begin
    if (chk_en) begin
      chk("busy",  32'(oLDST_BUSY),  32'(exp_busy));
      chk("valid", 32'(oLDST_VALID), 32'(exp_valid));
      chk("fault", 32'(oLDST_FAULT), 32'(exp_fault));
      chk("ldata", oLDST_DATA, exp_ldata);
      chk("mreq",  32'(oMEM_REQ),  32'(exp_req));
      chk("mrw",   32'(oMEM_RW),   32'(exp_rw));
      chk("mmask", 32'(oMEM_MASK), 32'(exp_mask));
      chk("maddr", oMEM_ADDR, exp_addr);
      chk("mdata", oMEM_DATA, exp_mdata);
      if (oMEM_REQ) begin
        seen_mask  <= oMEM_MASK;
        seen_maddr <= oMEM_ADDR;
        seen_mdata <= oMEM_DATA;
        req_cycles <= req_cycles + 1;
      end
      if (oLDST_VALID) begin
        seen_resp  <= oLDST_DATA;
        seen_fault <= oLDST_FAULT;
      end
    end
  end

  task automatic step();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_busy = 0; exp_req = 0; exp_valid = 0; exp_fault = 0; exp_rw = 0;
    exp_mask = 4'b0000; exp_addr = 32'h0; exp_mdata = 32'h0; exp_ldata = last_resp;
  endtask

  task automatic set_busy_exp();
    set_idle_exp();
    exp_busy = 1;
  endtask

  // rst_kind: 0 none, 1 soft reset in the first wait cycle, 2 hard reset there instead.
  task automatic run_txn(input logic [1:0] order, input logic rw, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] mem_word,
                         input int lock_n, input int wait_n, input int rst_kind);
    iLDST_USE = 1; iLDST_REQ = 1; iLDST_ORDER = order; iLDST_RW = rw;
    iLDST_ADDR = addr; iLDST_DATA = data; iMEM_LOCK = 0; iMEM_VALID = 0;
    set_idle_exp();
    step();
    // Requester keeps strobing with unrelated fields; none of it may be taken.
    iLDST_REQ = 1; iLDST_ADDR = $urandom; iLDST_DATA = $urandom;
    iLDST_ORDER = 2'($urandom_range(0, 3)); iLDST_RW = 1'($urandom_range(0, 1));
    if (m_misaligned(order, addr[1:0])) begin
      last_resp = 32'h0;
      set_busy_exp(); exp_valid = 1; exp_fault = 1;
      step();
    end else begin
      for (int i = 0; i <= lock_n; i++) begin
        iMEM_LOCK = (i < lock_n); iMEM_VALID = 1'($urandom_range(0, 1)); iMEM_DATA = $urandom;
        set_busy_exp();
        exp_req = 1; exp_rw = rw; exp_mask = m_mask(order, addr[1:0]);
        exp_addr = addr & 32'hFFFF_FFFC; exp_mdata = m_wdata(order, data);
        step();
      end
      if (rst_kind != 0) begin
        iMEM_LOCK = 1'($urandom_range(0, 1)); iMEM_VALID = 0;
        if (rst_kind == 1) iRESET_SYNC = 1; else inRESET = 0;
        set_busy_exp();
        step();
        iRESET_SYNC = 0; inRESET = 1; iLDST_USE = 0; iLDST_REQ = 0;
        iMEM_VALID = 1; iMEM_DATA = mem_word;
        last_resp = 32'h0;
        set_idle_exp();
        step();
        iMEM_VALID = 0;
        set_idle_exp();
        step();
        return;
      end
      for (int j = 0; j <= wait_n; j++) begin
        iMEM_LOCK = 1'($urandom_range(0, 1));
        iMEM_VALID = (j == wait_n);
        iMEM_DATA = (j == wait_n) ? mem_word : $urandom;
        set_busy_exp();
        step();
      end
      iMEM_VALID = 0;
      last_resp = rw ? 32'h0 : m_rdata(order, addr[1:0], mem_word);
      set_busy_exp(); exp_valid = 1;
      step();
    end
    // First cycle back in IDLE with the strobe withdrawn.
    iLDST_REQ = 0; iMEM_VALID = 0;
    set_idle_exp();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int r0;
    inRESET = 0; iRESET_SYNC = 0; iLDST_USE = 0; iLDST_REQ = 0; iLDST_ORDER = 0;
    iLDST_RW = 0; iLDST_ADDR = 0; iLDST_DATA = 0; iMEM_LOCK = 0; iMEM_VALID = 0; iMEM_DATA = 0;
    last_resp = 32'h0;
    set_idle_exp();
    step();
    chk_en = 1;
    step();
    inRESET = 1;
    step();

    run_txn(2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    chk("lit_word_addr", seen_maddr, 32'h0000_0104);
    chk("lit_word_mask", 32'(seen_mask), 32'hF);
    chk("lit_word_data", seen_resp, 32'hDEAD_BEEF);

    run_txn(2'b00, 1'b0, 32'h0000_0106, 32'h0, 32'h1122_3344, 0, 1, 0);
    chk("lit_byte_mask", 32'(seen_mask), 32'h2);
    chk("lit_byte_data", seen_resp, 32'h0000_0033);

    run_txn(2'b01, 1'b1, 32'h0000_0002, 32'h0000_ABCD, 32'h5555_5555, 0, 0, 0);
    chk("lit_half_mask", 32'(seen_mask), 32'h3);
    chk("lit_half_wdata", seen_mdata, 32'hABCD_ABCD);
    chk("lit_half_resp", seen_resp, 32'h0);

    r0 = req_cycles;
    run_txn(2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, 3, 0, 0);
    chk("lit_lock_req_cycles", 32'(req_cycles - r0), 32'd4);

    run_txn(2'b10, 1'b0, 32'h0000_0080, 32'h0, 32'h1234_5678, 0, 0, 1);
    chk("lit_reset_resp", oLDST_DATA, 32'h0);

    r0 = req_cycles;
    run_txn(2'b10, 1'b0, 32'h0000_0102, 32'h0, 32'hCAFE_0001, 0, 0, 0);
`ifdef PIPELINE_CONTROL_LDST_ALIGN_CHECK_EN
    chk("lit_misalign_req_cycles", 32'(req_cycles - r0), 32'd0);
    chk("lit_misalign_fault", 32'(seen_fault), 32'd1);
    chk("lit_misalign_data", seen_resp, 32'h0);
`else
    chk("lit_unaligned_req_cycles", 32'(req_cycles - r0), 32'd1);
    chk("lit_unaligned_mask", 32'(seen_mask), 32'hF);
    chk("lit_unaligned_addr", seen_maddr, 32'h0000_0100);
    chk("lit_unaligned_fault", 32'(seen_fault), 32'd0);
    chk("lit_unaligned_data", seen_resp, 32'hCAFE_0001);
`endif

    for (int t = 0; t < 200; t++) begin
      int rk;
      rk = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_txn(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rk);
      if ($urandom_range(0, 3) == 0) begin
        iMEM_VALID = 1; iMEM_DATA = $urandom;
        set_idle_exp();
        step();
        iMEM_VALID = 0;
      end
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
